// File: rtl/pci_mstr_single_pkg.sv
// pci_mstr_pkg: state, command and completion-status encodings shared by the PCI single-DWORD master.
package pci_mstr_pkg;
  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, TURN} state_t;
  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;
  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_MABORT = 2'b01;
  localparam logic [1:0] ST_TABORT = 2'b10;
  localparam logic [1:0] ST_RETRY  = 2'b11;
  function automatic logic [3:0] mem_cmd(input logic wr);
    return wr ? CMD_MEM_WR : CMD_MEM_RD;
  endfunction
endpackage

// File: rtl/pci_mstr_single_if.sv
// pci_mstr_single_if: local-requester handshake plus split in/out/oe PCI pad signals of the master.
interface pci_mstr_single_if;
  logic        lm_req;
  logic        lm_wr;
  logic [31:0] lm_addr;
  logic [31:0] lm_wdata;
  logic [3:0]  lm_ben;
  logic        lm_ack;
  logic [31:0] lm_rdata;
  logic [1:0]  lm_status;
  logic        reqn;
  logic        gntn;
  logic [31:0] ad_in;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic [3:0]  cben_out;
  logic        cben_oe;
  logic        par_out;
  logic        par_oe;
  logic        framen_in;
  logic        framen_out;
  logic        framen_oe;
  logic        irdyn_in;
  logic        irdyn_out;
  logic        irdyn_oe;
  logic        devseln;
  logic        trdyn;
  logic        stopn;
  modport master (
    input  lm_req, lm_wr, lm_addr, lm_wdata, lm_ben, gntn, ad_in, framen_in, irdyn_in,
           devseln, trdyn, stopn,
    output lm_ack, lm_rdata, lm_status, reqn, ad_out, ad_oe, cben_out, cben_oe,
           par_out, par_oe, framen_out, framen_oe, irdyn_out, irdyn_oe
  );
  modport slave (
    output lm_req, lm_wr, lm_addr, lm_wdata, lm_ben, gntn, ad_in, framen_in, irdyn_in,
           devseln, trdyn, stopn,
    input  lm_ack, lm_rdata, lm_status, reqn, ad_out, ad_oe, cben_out, cben_oe,
           par_out, par_oe, framen_out, framen_oe, irdyn_out, irdyn_oe
  );
endinterface

// File: rtl/pci_mstr_single_par_gen.sv
// pci_par_gen: registered even parity over AD and C/BE#, with the output enable delayed to match.
module pci_par_gen (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] ad_i,
  input  logic [3:0]  cben_i,
  input  logic        oe_i,
  output logic        par_o,
  output logic        par_oe_o
);
  logic par_q, oe_q;
  // parity only follows phases that actually drove AD; otherwise the last value is held
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      par_q <= 1'b1;
      oe_q  <= 1'b0;
    end else begin
      if (oe_i) par_q <= ^{ad_i, cben_i};
      oe_q <= oe_i;
    end
  assign par_o    = par_q;
  assign par_oe_o = oe_q;
endmodule

// File: rtl/pci_mstr_single.sv
// pci_mstr_single: PCI initiator issuing single-DWORD memory reads/writes for a local requester.
module pci_mstr_single
  import pci_mstr_pkg::*;
#(
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int RETRY_LIMIT    = 16
) (
  input logic               clk,
  input logic               rstn,
  pci_mstr_single_if.master bus
);
  localparam int CW = $clog2(DEVSEL_TIMEOUT + 1) + 1;
  state_t        state_q, state_d;
  logic          wr_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    ben_q;
  logic [15:0]   retry_q;
  logic [CW-1:0] dcnt_q;
  logic          seen_q, again_q, ack_q;
  logic [1:0]    st_q, status_q;
  logic          xfer, retry, tabort, mabort, limit, done;
  // exit conditions are mutually exclusive by construction, matching their priority order
  assign xfer   = !bus.trdyn && !bus.devseln;
  assign retry  = !bus.stopn && !bus.devseln && bus.trdyn;
  assign tabort = !bus.stopn && bus.devseln && seen_q;
  assign mabort = dcnt_q == CW'(DEVSEL_TIMEOUT) && !seen_q && bus.devseln;
  assign limit  = RETRY_LIMIT != 0 && retry_q + 16'd1 == 16'(RETRY_LIMIT);
  assign done   = xfer || retry || tabort || mabort;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.lm_req ? REQ : IDLE;
      REQ:     state_d = (!bus.gntn && bus.framen_in && bus.irdyn_in) ? ADDR : REQ;
      ADDR:    state_d = DATA;
      DATA:    state_d = done ? TURN : DATA;
      TURN:    state_d = again_q ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.reqn       = state_q != REQ;
    bus.framen_oe  = state_q inside {ADDR, DATA};
    bus.framen_out = state_q != ADDR;
    bus.irdyn_oe   = state_q inside {ADDR, DATA, TURN};
    bus.irdyn_out  = state_q != DATA;
    bus.cben_oe    = state_q inside {ADDR, DATA};
    bus.cben_out   = state_q == ADDR ? mem_cmd(wr_q) : state_q == DATA ? ben_q : 4'hF;
    bus.ad_oe      = state_q == ADDR || (state_q == DATA && wr_q);
    bus.ad_out     = state_q == ADDR ? {addr_q[31:2], 2'b00} :
                     (state_q == DATA && wr_q) ? wdata_q : 32'h0;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ben_q    <= 4'hF;
      retry_q  <= '0;
      dcnt_q   <= '0;
      seen_q   <= 1'b0;
      again_q  <= 1'b0;
      st_q     <= ST_OK;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      status_q <= ST_OK;
    end else begin
      ack_q <= state_q == TURN && !again_q;
      if (state_q == IDLE && bus.lm_req) begin
        wr_q    <= bus.lm_wr;
        addr_q  <= bus.lm_addr;
        wdata_q <= bus.lm_wdata;
        ben_q   <= bus.lm_ben;
        retry_q <= '0;
      end
      if (state_q == ADDR) begin
        dcnt_q <= CW'(1);
        seen_q <= 1'b0;
      end
      if (state_q == DATA) begin
        dcnt_q <= dcnt_q + CW'(1);
        seen_q <= seen_q || !bus.devseln;
        if (done) begin
          again_q <= retry && !limit;
          st_q    <= xfer ? ST_OK : retry ? ST_RETRY : tabort ? ST_TABORT : ST_MABORT;
          if (retry) retry_q <= retry_q + 16'd1;
          if (xfer && !wr_q) rdata_q <= bus.ad_in;
        end
      end
      if (state_q == TURN && !again_q) status_q <= st_q;
    end
  assign bus.lm_ack    = ack_q;
  assign bus.lm_rdata  = rdata_q;
  assign bus.lm_status = status_q;
  pci_par_gen u_par (
    .clk      (clk),
    .rstn     (rstn),
    .ad_i     (bus.ad_out),
    .cben_i   (bus.cben_out),
    .oe_i     (bus.ad_oe),
    .par_o    (bus.par_out),
    .par_oe_o (bus.par_oe)
  );
endmodule

// File: tb/tb_pci_mstr_single.sv
// tb_pci_mstr_single: directed PCI target/arbiter model with an ack-driven scoreboard for two master instances.
module tb_pci_mstr_single;
  import pci_mstr_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;
  pci_mstr_single_if b0();
  pci_mstr_single_if b1();
  pci_mstr_single #(.DEVSEL_TIMEOUT(5), .RETRY_LIMIT(16)) dut  (.clk(clk), .rstn(rstn), .bus(b0));
  pci_mstr_single #(.DEVSEL_TIMEOUT(5), .RETRY_LIMIT(2))  dut2 (.clk(clk), .rstn(rstn), .bus(b1));
  assign b1.lm_req    = b0.lm_req;
  assign b1.lm_wr     = b0.lm_wr;
  assign b1.lm_addr   = b0.lm_addr;
  assign b1.lm_wdata  = b0.lm_wdata;
  assign b1.lm_ben    = b0.lm_ben;
  assign b1.gntn      = b0.gntn;
  assign b1.ad_in     = b0.ad_in;
  assign b1.framen_in = b0.framen_in;
  assign b1.irdyn_in  = b0.irdyn_in;
  assign b1.devseln   = b0.devseln;
  assign b1.trdyn     = b0.trdyn;
  assign b1.stopn     = b0.stopn;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  ben;
    logic [1:0]  st;
    logic [1:0]  st2;
    logic [31:0] rd;
    int          lat;
    int          lreq;
    int          naddr;
    int          rcyc;
  } item_t;
  item_t q[$];
  item_t q2[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_addr = 0, addr_n = 0, k = 0, acks = 0;
  int t_mode = 0, t_dev = 1, t_trdy = 1, t_retries = 0;
  logic [31:0] t_rdata = 32'h0;
  logic arb_en = 1'b1;
  logic gnt_smp = 1'b1;
  logic p_oe = 1'b0;
  logic [31:0] p_ad = 32'h0;
  logic [3:0] p_cb = 4'hF;
  logic adr, dat, trn;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    gnt_smp <= b0.gntn;
  end
  // monitor, scoreboard consumer, arbiter and target model all act on the falling edge
  always @(negedge clk) begin
    adr = b0.framen_oe && !b0.framen_out;
    dat = b0.framen_oe && b0.framen_out && !b0.irdyn_out;
    trn = b0.irdyn_oe && !b0.framen_oe;
    if (!rstn) begin
      p_oe = 1'b0;
      addr_n = 0;
      k = 0;
    end else begin
      if (p_oe) begin
        chk("par_value", b0.par_out, ^{p_ad, p_cb});
        chk("par_oe_on", b0.par_oe, 1);
      end else chk("par_oe_off", b0.par_oe, 0);
      p_oe = b0.ad_oe;
      p_ad = b0.ad_out;
      p_cb = b0.cben_out;
      if (adr) begin
        addr_n++;
        last_addr = cyc;
        k = 0;
        chk("addr_gnt_sampled", gnt_smp, 0);
        chk("addr_oe_irdy_reqn", {b0.ad_oe, b0.cben_oe, b0.irdyn_oe, b0.irdyn_out, b0.reqn}, 5'b11111);
        if (q.size() > 0) begin
          chk("addr_ad", b0.ad_out, {q[0].addr[31:2], 2'b00});
          chk("addr_cmd", b0.cben_out, q[0].wr ? 4'b0111 : 4'b0110);
        end
      end
      if (dat) begin
        k++;
        if (q.size() > 0) begin
          chk("data_ben", b0.cben_out, q[0].ben);
          if (q[0].wr) chk("data_wdata", {b0.ad_oe, b0.ad_out}, {1'b1, q[0].wd});
          else chk("data_read_ad_oe", b0.ad_oe, 0);
        end
      end
      if (trn) chk("turn_release", {b0.framen_oe, b0.ad_oe, b0.cben_oe, b0.irdyn_oe, b0.irdyn_out, b0.reqn}, 6'b000111);
      if (b0.lm_ack) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected got ack status %0h want no ack", b0.lm_status);
        end else begin
          item_t it;
          it = q.pop_front();
          chk("ack_status", b0.lm_status, it.st);
          if (!it.wr && it.st == ST_OK) chk("ack_rdata", b0.lm_rdata, it.rd);
          if (it.lat >= 0) chk("ack_lat_from_addr", cyc - last_addr, it.lat);
          if (it.lreq >= 0) chk("ack_lat_from_req", cyc - it.rcyc, it.lreq);
          if (it.naddr >= 0) chk("ack_addr_phases", addr_n, it.naddr);
        end
        addr_n = 0;
        acks++;
      end
    end
    b0.gntn = (arb_en && !b0.reqn) ? 1'b0 : 1'b1;
    b0.devseln = 1'b1;
    b0.trdyn = 1'b1;
    b0.stopn = 1'b1;
    b0.ad_in = 32'hBAD0_BAD0;
    if (dat && rstn) begin
      if (t_mode == 3 && addr_n <= t_retries) begin
        b0.devseln = 1'b0;
        b0.stopn = 1'b0;
      end else if (t_mode == 2) begin
        b0.devseln = k != 1;
        b0.stopn = k == 1;
      end else if (t_mode != 1) begin
        b0.devseln = !(k >= t_dev);
        b0.trdyn = !(k >= t_trdy);
        if (k >= t_trdy && k >= t_dev) b0.ad_in = t_rdata;
      end
    end
  end
  always @(negedge clk)
    if (rstn && b1.lm_ack) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack2_unexpected got ack status %0h want no ack", b1.lm_status);
      end else begin
        item_t it;
        it = q2.pop_front();
        chk("ack2_status", b1.lm_status, it.st2);
        if (!it.wr && it.st2 == ST_OK) chk("ack2_rdata", b1.lm_rdata, it.rd);
      end
    end
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ben,
                     input logic [1:0] st, input logic [1:0] st2, input logic [31:0] rd,
                     input int lat, input int lreq, input int naddr, input int hold);
    item_t it;
    int a0;
    @(negedge clk);
    it.wr = wr; it.addr = a; it.wd = wd; it.ben = ben; it.st = st; it.st2 = st2; it.rd = rd;
    it.lat = lat; it.lreq = lreq; it.naddr = naddr; it.rcyc = cyc;
    q.push_back(it);
    q2.push_back(it);
    a0 = acks;
    b0.lm_req = 1'b1; b0.lm_wr = wr; b0.lm_addr = a; b0.lm_wdata = wd; b0.lm_ben = ben;
    @(negedge clk);
    b0.lm_req = 1'b0;
    if (hold > 0) begin
      @(negedge clk);
      b0.lm_req = 1'b1; b0.lm_addr = 32'hFFFF_FFF0; b0.lm_wr = !wr;
      @(negedge clk);
      b0.lm_req = 1'b0;
      repeat (hold) @(negedge clk);
      chk("hold_no_addr_phase", addr_n, 0);
      chk("hold_reqn_asserted", b0.reqn, 0);
      arb_en = 1'b1;
      b0.framen_in = 1'b1;
    end
    for (int i = 0; i < 100 && acks == a0; i++) @(negedge clk);
    if (acks == a0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout got no ack want ack within 100 cycles");
      q.delete();
      q2.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    b0.lm_req = 1'b0; b0.lm_wr = 1'b0; b0.lm_addr = '0; b0.lm_wdata = '0; b0.lm_ben = 4'hF;
    b0.gntn = 1'b1; b0.ad_in = '0; b0.framen_in = 1'b1; b0.irdyn_in = 1'b1;
    b0.devseln = 1'b1; b0.trdyn = 1'b1; b0.stopn = 1'b1;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_reqn", b0.reqn, 1);
    chk("rst_oes", {b0.ad_oe, b0.cben_oe, b0.par_oe, b0.framen_oe, b0.irdyn_oe}, 5'b00000);
    chk("rst_framen_irdyn_par", {b0.framen_out, b0.irdyn_out, b0.par_out}, 3'b111);
    chk("rst_ad_out", b0.ad_out, 0);
    chk("rst_cben_out", b0.cben_out, 4'hF);
    chk("rst_lm_outs", {b0.lm_ack, b0.lm_rdata, b0.lm_status}, 35'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    t_mode = 0; t_dev = 1; t_trdy = 1;
    txn(1'b1, 32'h2000_0010, 32'h0102_0304, 4'b0101, ST_OK, ST_OK, 32'h0, 3, 5, 1, 0);
    t_dev = 2; t_trdy = 2;
    txn(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'h0, ST_OK, ST_OK, 32'h0, 4, 6, 1, 0);
    t_dev = 1; t_trdy = 3; t_rdata = 32'h1234_5678;
    txn(1'b0, 32'h1000_0080, 32'h0, 4'h0, ST_OK, ST_OK, 32'h1234_5678, 5, 7, 1, 0);
    t_trdy = 1; t_rdata = 32'hCAFE_F00D;
    txn(1'b0, 32'h0000_0107, 32'h0, 4'b1100, ST_OK, ST_OK, 32'hCAFE_F00D, 3, 5, 1, 0);
    t_mode = 1;
    txn(1'b0, 32'h4000_0000, 32'h0, 4'h0, ST_MABORT, ST_MABORT, 32'h0, 7, 9, 1, 0);
    t_mode = 3; t_retries = 3;
    txn(1'b1, 32'h3000_0000, 32'h5555_AAAA, 4'b0011, ST_OK, ST_RETRY, 32'h0, 3, -1, 4, 0);
    t_mode = 2;
    txn(1'b1, 32'h5000_0004, 32'h0F0F_0F0F, 4'h0, ST_TABORT, ST_TABORT, 32'h0, 4, 6, 1, 0);
    t_mode = 0; t_rdata = 32'h0BAD_CAFE; arb_en = 1'b0;
    txn(1'b0, 32'h6000_0008, 32'h0, 4'h0, ST_OK, ST_OK, 32'h0BAD_CAFE, 3, -1, 1, 6);
    b0.framen_in = 1'b0;
    txn(1'b1, 32'h7000_000C, 32'hA5A5_5A5A, 4'b1000, ST_OK, ST_OK, 32'h0, 3, -1, 1, 4);
    t_mode = 1;
    @(negedge clk);
    b0.lm_req = 1'b1; b0.lm_wr = 1'b0; b0.lm_addr = 32'h8000_0000;
    @(negedge clk);
    b0.lm_req = 1'b0;
    for (int i = 0; i < 20 && !(b0.framen_oe && b0.framen_out && !b0.irdyn_out); i++) @(negedge clk);
    @(negedge clk);
    chk("pre_rst_in_data", {b0.framen_oe, b0.irdyn_oe, b0.irdyn_out}, 3'b110);
    rstn = 1'b0;
    #1;
    chk("rst_mid_release", {b0.reqn, b0.ad_oe, b0.cben_oe, b0.framen_oe, b0.irdyn_oe, b0.par_oe}, 6'b100000);
    chk("rst_mid_release2", {b1.reqn, b1.ad_oe, b1.cben_oe, b1.framen_oe, b1.irdyn_oe, b1.par_oe}, 6'b100000);
    begin
      int a0;
      a0 = acks;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_mid_no_ack", acks, a0);
    end
    t_mode = 0; t_dev = 1; t_trdy = 1; t_rdata = 32'h7777_0001;
    txn(1'b0, 32'h9000_0010, 32'h0, 4'h0, ST_OK, ST_OK, 32'h7777_0001, 3, 5, 1, 0);
    chk("scoreboard_drained", q.size() + q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
